// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared CSR addresses, op encodings and read-modify-write helper
package csr_pkg;

  localparam int CSR_MAX_XLEN = 64;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam logic [2:0] CSR_OP_RW  = 3'b001;
  localparam logic [2:0] CSR_OP_RS  = 3'b010;
  localparam logic [2:0] CSR_OP_RC  = 3'b011;
  localparam logic [2:0] CSR_OP_RWI = 3'b101;
  localparam logic [2:0] CSR_OP_RSI = 3'b110;
  localparam logic [2:0] CSR_OP_RCI = 3'b111;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // kind is funct3[1:0]; the immediate forms share the register datapath
  function automatic logic [CSR_MAX_XLEN-1:0] csr_new_value(
    input logic [1:0]              kind,
    input logic [CSR_MAX_XLEN-1:0] old,
    input logic [CSR_MAX_XLEN-1:0] operand
  );
    case (kind)
      2'b01:   csr_new_value = operand;
      2'b10:   csr_new_value = old | operand;
      2'b11:   csr_new_value = old & ~operand;
      default: csr_new_value = old;
    endcase
  endfunction

endpackage

// File: rtl/csr_unit_if.sv
// rtl/csr_unit_if.sv - CSR instruction request/response bundle between EX and csr_unit
interface csr_unit_if #(
  parameter int XLEN = 32
);
  logic            csr_valid;
  logic [2:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] op1;
  logic            src_zero;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;

  modport master (
    output csr_valid, csr_op, csr_addr, op1, src_zero,
    input  csr_rdata, csr_illegal
  );

  modport slave (
    input  csr_valid, csr_op, csr_addr, op1, src_zero,
    output csr_rdata, csr_illegal
  );
endinterface

// File: rtl/csr_counter.sv
// rtl/csr_counter.sv - wide free-running counter with independently writable halves
module csr_counter #(
  parameter int CNT_WIDTH = 64,
  parameter int XLEN      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [XLEN-1:0]      wdata,
  output logic [CNT_WIDTH-1:0] value
);
  localparam int HI_W = CNT_WIDTH - XLEN;

  // A write to either half replaces only that half and swallows this cycle's increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
    end else if (wr_lo) begin
      value[XLEN-1:0] <= wdata;
    end else if (wr_hi) begin
      value[CNT_WIDTH-1:XLEN] <= wdata[HI_W-1:0];
    end else if (inc) begin
      value <= value + CNT_WIDTH'(1);
    end
  end
endmodule

// File: rtl/csr_unit.sv
// rtl/csr_unit.sv - machine-mode CSR file with RW/RS/RC datapath, counters and trap/MRET updates
module csr_unit
  import csr_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              CNT_WIDTH   = 64,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter logic [XLEN-1:0] HART_ID     = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  csr_unit_if.slave        csr,
  input  logic             instret_pulse,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_pc,
  input  logic [XLEN-1:0]  trap_cause,
  input  logic             mret_valid,
  output logic [XLEN-1:0]  mtvec_out,
  output logic [XLEN-1:0]  mepc_out,
  output logic             mie_out
);

  logic                 mie;
  logic                 mpie;
  logic [XLEN-1:0]      mtvec;
  logic [XLEN-1:0]      mscratch;
  logic [XLEN-1:0]      mepc;
  logic [XLEN-1:0]      mcause;
  logic [CNT_WIDTH-1:0] mcycle;
  logic [CNT_WIDTH-1:0] minstret;

  logic [XLEN-1:0] mstatus_val;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;
  logic            mapped;
  logic            op_ok;
  logic            wr_intent;
  logic            illegal;
  logic            do_write;

  always_comb begin
    mstatus_val               = '0;
    mstatus_val[MSTATUS_MIE]  = mie;
    mstatus_val[MSTATUS_MPIE] = mpie;
  end

  always_comb begin
    old_val = '0;
    mapped  = 1'b1;
    case (csr.csr_addr)
      CSR_MSTATUS:                old_val = mstatus_val;
      CSR_MTVEC:                  old_val = mtvec;
      CSR_MSCRATCH:               old_val = mscratch;
      CSR_MEPC:                   old_val = mepc;
      CSR_MCAUSE:                 old_val = mcause;
      CSR_MCYCLE, CSR_CYCLE:      old_val = mcycle[XLEN-1:0];
      CSR_MCYCLEH, CSR_CYCLEH:    old_val = XLEN'(mcycle[CNT_WIDTH-1:XLEN]);
      CSR_MINSTRET, CSR_INSTRET:  old_val = minstret[XLEN-1:0];
      CSR_MINSTRETH, CSR_INSTRETH: old_val = XLEN'(minstret[CNT_WIDTH-1:XLEN]);
      CSR_MHARTID:                old_val = HART_ID;
      default:                    mapped  = 1'b0;
    endcase
  end

  // funct3 x00 is not a CSR op; set/clear with a zero source is a pure read
  assign op_ok     = (csr.csr_op[1:0] != 2'b00);
  assign wr_intent = (csr.csr_op[1:0] == 2'b01) | ~csr.src_zero;
  assign illegal   = csr.csr_valid &
                     (~op_ok | ~mapped | (wr_intent & (csr.csr_addr[11:10] == 2'b11)));
  assign do_write  = csr.csr_valid & ~illegal & wr_intent & ~trap_valid & ~mret_valid;

  assign new_val = XLEN'(csr_new_value(csr.csr_op[1:0],
                                       CSR_MAX_XLEN'(old_val),
                                       CSR_MAX_XLEN'(csr.op1)));

  assign csr.csr_illegal = illegal;
  assign csr.csr_rdata   = (csr.csr_valid && !illegal) ? old_val : '0;

  assign mtvec_out = mtvec;
  assign mepc_out  = mepc;
  assign mie_out   = mie;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= MTVEC_RESET;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
    end else if (trap_valid) begin
      mepc   <= {trap_pc[XLEN-1:2], 2'b00};
      mcause <= trap_cause;
      mpie   <= mie;
      mie    <= 1'b0;
    end else if (mret_valid) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (do_write) begin
      case (csr.csr_addr)
        CSR_MSTATUS: begin
          mie  <= new_val[MSTATUS_MIE];
          mpie <= new_val[MSTATUS_MPIE];
        end
        CSR_MTVEC:    mtvec    <= new_val;
        CSR_MSCRATCH: mscratch <= new_val;
        CSR_MEPC:     mepc     <= {new_val[XLEN-1:2], 2'b00};
        CSR_MCAUSE:   mcause   <= new_val;
        default: ;
      endcase
    end
  end

  csr_counter #(.CNT_WIDTH(CNT_WIDTH), .XLEN(XLEN)) u_mcycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .wr_lo (do_write && csr.csr_addr == CSR_MCYCLE),
    .wr_hi (do_write && csr.csr_addr == CSR_MCYCLEH),
    .wdata (new_val),
    .value (mcycle)
  );

  csr_counter #(.CNT_WIDTH(CNT_WIDTH), .XLEN(XLEN)) u_minstret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (instret_pulse),
    .wr_lo (do_write && csr.csr_addr == CSR_MINSTRET),
    .wr_hi (do_write && csr.csr_addr == CSR_MINSTRETH),
    .wdata (new_val),
    .value (minstret)
  );

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Parametrised successor to the combinational CSR ALU: merges the RW/RS/RC read-modify-write datapath with an architectural machine-mode CSR register file.
- Adds immediate variants, write-suppression rules, illegal-access detection, free-running cycle/instret counters, and trap entry/MRET state updates.
- Sits in the EX stage; reads combinationally, commits writes on the next clk edge.

Parameters:
- XLEN, 32, data width of CSRs and operands.
- CNT_WIDTH, 64, width of mcycle/minstret; upper XLEN bits exposed via *h addresses; must be > XLEN and <= 2*XLEN.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
- HART_ID, 0, value returned by mhartid.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- csr_valid  in  1  CSR instruction in EX this cycle
- csr_op  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- csr_addr  in  12  CSR address
- op1  in  XLEN  rs1 data, or zero-extended zimm for the I forms
- src_zero  in  1  rs1 index / zimm field == 0
- csr_rdata  out  XLEN  old CSR value (to rd)
- csr_illegal  out  1  illegal CSR access
- instret_pulse  in  1  one instruction retired this cycle
- trap_valid  in  1  take trap this cycle
- trap_pc  in  XLEN  PC to save in mepc
- trap_cause  in  XLEN  value for mcause
- mret_valid  in  1  MRET executing
- mtvec_out  out  XLEN  current mtvec
- mepc_out  out  XLEN  current mepc
- mie_out  out  1  mstatus.MIE

Behaviour:
- Address map:
  - mstatus 0x300: only MIE[3] and MPIE[7] are writable; all other bits read 0.
  - mtvec 0x305.
  - mscratch 0x340.
  - mepc 0x341: bits[1:0] are forced to 0.
  - mcause 0x342.
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82.
  - Read-only: cycle/cycleh 0xC00/0xC80, instret/instreth 0xC02/0xC82, mhartid 0xF14.
- csr_rdata: combinational, equal to the current CSR value; 0 when the access is illegal or csr_valid=0.
- New value:
  - RW: op1.
  - RS: old | op1.
  - RC: old & ~op1.
- Write intent: RW/RWI always write. RS/RC/RSI/RCI write only when src_zero=0.
- csr_illegal=1 when csr_valid and any of the following holds. On an illegal access no state changes.
  - csr_op is 000 or 100.
  - The address is unmapped.
  - There is write intent and csr_addr[11:10]==2'b11.
- Write commit: at the next rising clk edge, visible in the following cycle (1-cycle latency). Back-to-back CSR instructions see the updated value.
- Counters:
  - mcycle increments every cycle.
  - minstret increments when instret_pulse=1.
  - Both wrap at 2^CNT_WIDTH.
  - A CSR write to the low or high half replaces that half and suppresses the increment for that counter in that cycle; the other half is untouched (no carry from the written value).
- Trap entry (trap_valid=1): mepc<=trap_pc&~3, mcause<=trap_cause, MPIE<=MIE, MIE<=0.
- MRET (mret_valid=1 and trap_valid=0): MIE<=MPIE, MPIE<=1.
- Priority, highest first: trap_valid > mret_valid > CSR write. Any CSR write in a trap or MRET cycle is dropped entirely, including mscratch. Counters still advance in those cycles.
- Reset (rst_n=0 at clk edge, including mid-operation):
  - mstatus=0, mtvec=MTVEC_RESET, mscratch=0, mepc=0, mcause=0, mcycle=0, minstret=0.
  - Outputs follow: mie_out=0, mtvec_out=MTVEC_RESET, mepc_out=0.
  - Pending writes, traps and increments in the reset cycle are discarded.

Decomposition:
- Shared package csr_pkg:
  - CSR address localparams.
  - csr_op encodings.
  - mstatus bit positions (MIE=3, MPIE=7).
  - Helper function for the RW/RS/RC new-value calculation.
- Sub-module csr_counter, parametrised by CNT_WIDTH and XLEN:
  - Synchronous reset.
  - inc enable.
  - Separate wr_lo/wr_hi strobes with wdata.
  - Full-width value output.
  - Instantiated twice (mcycle, minstret).

Test Plan:
- Reset, then csr_valid RW addr 0x340 op1=32'hDEADBEEF -> rdata=0 that cycle; next cycle RS addr 0x340 op1=32'h0000000F, src_zero=0 -> rdata=32'hDEADBEEF; the following read returns 32'hDEADBEEF (0xF bits already set).
- RC addr 0x300 with src_zero=1 after MIE=1 -> rdata=32'h8 and mstatus unchanged; RSI addr 0xC00 src_zero=1 -> legal read, no illegal; RW addr 0xC00 -> csr_illegal=1, rdata=0, counters unaffected.
- Write mcycle=32'hFFFFFFFF, then wait 1 cycle -> mcycle low=0, mcycleh=1 (carry crosses halves); write mcycleh=5 -> the next read of 0xB80 returns 5; 0xB00 continued incrementing.
- MIE=1, trap_valid with trap_pc=32'h1002, trap_cause=32'h8000000B, plus a simultaneous RW to 0x340 -> mepc=32'h1000, mcause=32'h8000000B, MIE=0, MPIE=1, mscratch unchanged.
- mret_valid after the trap -> MIE=1, MPIE=1; trap_valid and mret_valid together -> trap semantics only.
- Assert rst_n=0 mid-sequence with mscratch=32'h1234 and a write pending -> next cycle all CSRs at reset values, mtvec_out=MTVEC_RESET, csr_op=100 -> csr_illegal=1.
